// File: rtl/adapter_ppfifo_2_axi_stream_wl_pkg.sv
// adapter_ppfifo_2_axi_stream_wl_pkg: shared FSM encodings and PPFIFO size width
package adapter_ppfifo_2_axi_stream_wl_pkg;

    localparam int SIZE_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RELEASE
    } state_t;

endpackage

// File: rtl/adapter_ppfifo_2_axi_stream_wl_skid_buf.sv
// ppfifo_rd_skid_buf: 2-entry FIFO absorbing PPFIFO read latency ahead of the AXI output
module ppfifo_rd_skid_buf #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_count;

    // storage, pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '{default: '0};
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_mem[r_wr] <= i_data;
            r_wr    <= r_wr ^ i_push;
            r_rd    <= r_rd ^ i_pop;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/adapter_ppfifo_2_axi_stream_wl.sv
// adapter_ppfifo_2_axi_stream_wl: claims filled PPFIFO blocks and streams their words out as AXI-stream
module adapter_ppfifo_2_axi_stream_wl
    import adapter_ppfifo_2_axi_stream_wl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter bit USE_LAST_BIT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    o_ppfifo_clk,
    input  logic                    i_ppfifo_rdy,
    output logic                    o_ppfifo_act,
    input  logic [SIZE_W-1:0]       i_ppfifo_size,
    output logic                    o_ppfifo_stb,
    input  logic [DATA_WIDTH:0]     i_ppfifo_data,
    output logic                    o_axi_valid,
    input  logic                    i_axi_ready,
    output logic [DATA_WIDTH-1:0]   o_axi_data,
    output logic [STROBE_WIDTH-1:0] o_axi_keep,
    output logic                    o_axi_last
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SIZE_W-1:0]   r_count;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [1:0]          w_occ;
    logic [2:0]          w_use;
    logic                w_pop;
    logic                w_stb;
    logic [DATA_WIDTH:0] w_head;
    logic [DATA_WIDTH:0] w_push_word;

    // a beat popped this clock frees its slot in time for a word requested now
    assign w_pop  = o_axi_valid && i_axi_ready;
    assign w_use  = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_stb  = (r_state == ST_ACTIVE) && (r_count < i_ppfifo_size) && (w_use < 3'd2);

    assign w_push_word = {USE_LAST_BIT ? i_ppfifo_data[DATA_WIDTH] : r_inflight_last,
                          i_ppfifo_data[DATA_WIDTH-1:0]};

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // claim when a block is ready, release once every requested word has landed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    w_state_nxt = i_ppfifo_rdy ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE:  w_state_nxt = (r_count == i_ppfifo_size && !r_inflight) ? ST_RELEASE : ST_ACTIVE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // word counter and record of the read whose data arrives next clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_count         <= (r_state == ST_IDLE) ? '0 : r_count + SIZE_W'(w_stb);
            r_inflight      <= w_stb;
            r_inflight_last <= (r_count == i_ppfifo_size - 1'b1);
        end
    end

    ppfifo_rd_skid_buf #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_inflight),
        .i_data (w_push_word),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_count(w_occ)
    );

    assign o_ppfifo_clk = clk;
    assign o_ppfifo_act = (r_state == ST_ACTIVE);
    assign o_ppfifo_stb = w_stb;
    assign o_axi_valid  = (w_occ != 2'd0);
    assign o_axi_data   = w_head[DATA_WIDTH-1:0];
    assign o_axi_last   = w_head[DATA_WIDTH];
    assign o_axi_keep   = '1;

endmodule

// File: tb/tb_adapter_ppfifo_2_axi_stream_wl.sv
// tb_adapter_ppfifo_2_axi_stream_wl: randomized PPFIFO/AXI scenarios against a block-level reference
module tb_adapter_ppfifo_2_axi_stream_wl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_ppfifo_rdy = 1'b0;
    logic [23:0] i_ppfifo_size = '0;
    logic [32:0] i_ppfifo_data = '0;
    logic        i_axi_ready = 1'b0;
    logic        o_ppfifo_clk, o_ppfifo_act, o_ppfifo_stb, o_axi_valid, o_axi_last;
    logic [31:0] o_axi_data;
    logic [3:0]  o_axi_keep;
    logic        n_ppfifo_clk, n_ppfifo_act, n_ppfifo_stb, n_axi_valid, n_axi_last;
    logic [31:0] n_axi_data;
    logic [3:0]  n_axi_keep;

    always #5 clk = ~clk;

    adapter_ppfifo_2_axi_stream_wl #(.DATA_WIDTH(32), .USE_LAST_BIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .o_ppfifo_clk(o_ppfifo_clk), .i_ppfifo_rdy(i_ppfifo_rdy),
        .o_ppfifo_act(o_ppfifo_act), .i_ppfifo_size(i_ppfifo_size), .o_ppfifo_stb(o_ppfifo_stb),
        .i_ppfifo_data(i_ppfifo_data), .o_axi_valid(o_axi_valid), .i_axi_ready(i_axi_ready),
        .o_axi_data(o_axi_data), .o_axi_keep(o_axi_keep), .o_axi_last(o_axi_last)
    );

    adapter_ppfifo_2_axi_stream_wl #(.DATA_WIDTH(32), .USE_LAST_BIT(1'b0)) dut_nl (
        .clk(clk), .rst_n(rst_n), .o_ppfifo_clk(n_ppfifo_clk), .i_ppfifo_rdy(i_ppfifo_rdy),
        .o_ppfifo_act(n_ppfifo_act), .i_ppfifo_size(i_ppfifo_size), .o_ppfifo_stb(n_ppfifo_stb),
        .i_ppfifo_data(i_ppfifo_data), .o_axi_valid(n_axi_valid), .i_axi_ready(i_axi_ready),
        .o_axi_data(n_axi_data), .o_axi_keep(n_axi_keep), .o_axi_last(n_axi_last)
    );

    int vectors = 0;
    int errors = 0;

    logic [32:0] blk [0:63];
    logic [31:0] got_data [$];
    logic        got_last [$];
    logic        got_last_nl [$];
    int          got_cyc [$];
    int          rd_idx, stb_count, act_ticks, first_valid, tick_no, stall_breaks, diverge;
    logic        s_stb, s_act, s_valid, s_last, s_last_nl, p_valid, p_ready, p_last;
    logic [31:0] s_data, p_data;

    // one clock: observe at negedge, play the PPFIFO read port after the edge
    task automatic tick();
        @(negedge clk);
        s_stb = o_ppfifo_stb; s_act = o_ppfifo_act; s_valid = o_axi_valid;
        s_data = o_axi_data; s_last = o_axi_last; s_last_nl = n_axi_last;
        if (n_ppfifo_stb !== s_stb || n_axi_valid !== s_valid || n_axi_data !== s_data) diverge++;
        if (p_valid && !p_ready && (!s_valid || s_data !== p_data || s_last !== p_last)) stall_breaks++;
        if (s_act) act_ticks++;
        if (s_valid && first_valid < 0) first_valid = tick_no;
        if (s_valid && i_axi_ready) begin
            got_data.push_back(s_data); got_last.push_back(s_last);
            got_last_nl.push_back(s_last_nl); got_cyc.push_back(tick_no);
        end
        p_valid = s_valid; p_ready = i_axi_ready; p_data = s_data; p_last = s_last;
        @(posedge clk); #1;
        if (s_stb) begin
            i_ppfifo_data = blk[rd_idx[5:0]];
            rd_idx++;
            stb_count++;
        end
        if (s_act) i_ppfifo_rdy = 1'b0;
        tick_no++;
    endtask

    task automatic fill_block(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            logic [31:0] d;
            logic        l;
            d = (kind == 0) ? 32'hA0 + 32'(i) : $urandom;
            l = (kind == 0) ? (i == n - 1) : (kind == 1) ? 1'($urandom) : 1'b0;
            blk[i] = {l, d};
        end
    endtask

    task automatic begin_block(input int n);
        rd_idx = 0; stb_count = 0; act_ticks = 0; first_valid = -1; tick_no = 0;
        stall_breaks = 0; diverge = 0; p_valid = 1'b0;
        got_data.delete(); got_last.delete(); got_last_nl.delete(); got_cyc.delete();
        i_ppfifo_size = 24'(n);
        i_ppfifo_rdy = 1'b1;
    endtask

    // mode 0: ready high, 1: toggling, 2: random; abort>=0 returns after that many beats
    task automatic finish_block(input int n, input int mode, input int abort);
        for (int c = 0; c < 400; c++) begin
            i_axi_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom);
            tick();
            if (abort >= 0 && got_data.size() >= abort) return;
            if (act_ticks > 0 && !s_act && !s_valid && got_data.size() >= n) break;
        end
        i_axi_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 6;
        if (o_ppfifo_act !== 1'b0) begin errors++; $display("FAIL reset_act: got %b expected 0", o_ppfifo_act); end
        if (o_ppfifo_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", o_ppfifo_stb); end
        if (o_axi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_axi_valid); end
        if (o_axi_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", o_axi_data); end
        if (o_axi_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", o_axi_last); end
        if (o_axi_keep !== 4'hF) begin errors++; $display("FAIL keep: got %h expected f", o_axi_keep); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        fill_block(4, 0);
        begin_block(4);
        finish_block(4, 0, -1);
        vectors += 5;
        if (got_data.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", got_data.size()); end
        if (first_valid !== 3) begin errors++; $display("FAIL b2b_latency: got %0d expected 3", first_valid); end
        if (got_data.size() == 4 && got_cyc[3] - got_cyc[0] !== 3) begin
            errors++; $display("FAIL b2b_spacing: got %0d expected 3", got_cyc[3] - got_cyc[0]);
        end
        if (s_act !== 1'b0) begin errors++; $display("FAIL b2b_act: got %b expected 0", s_act); end
        if (stb_count !== 4) begin errors++; $display("FAIL b2b_stb: got %0d expected 4", stb_count); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            vectors += 2;
            if (got_data[i] !== blk[i][31:0]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_data[i], blk[i][31:0]); end
            if (got_last[i] !== (i == 3)) begin errors++; $display("FAIL b2b_last[%0d]: got %b expected %b", i, got_last[i], i == 3); end
        end
    endtask

    task automatic test_toggle_ready();
        fill_block(8, 1);
        begin_block(8);
        finish_block(8, 1, -1);
        vectors += 3;
        if (got_data.size() !== 8) begin errors++; $display("FAIL tog_count: got %0d expected 8", got_data.size()); end
        if (stall_breaks !== 0) begin errors++; $display("FAIL tog_stable: got %0d breaks expected 0", stall_breaks); end
        if (stb_count !== 8) begin errors++; $display("FAIL tog_stb: got %0d expected 8", stb_count); end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            vectors += 2;
            if (got_data[i] !== blk[i][31:0]) begin errors++; $display("FAIL tog_data[%0d]: got %h expected %h", i, got_data[i], blk[i][31:0]); end
            if (got_last[i] !== blk[i][32]) begin errors++; $display("FAIL tog_last[%0d]: got %b expected %b", i, got_last[i], blk[i][32]); end
        end
    endtask

    task automatic test_stall();
        fill_block(8, 1);
        begin_block(8);
        i_axi_ready = 1'b0;
        repeat (10) tick();
        vectors += 4;
        if (stb_count !== 2) begin errors++; $display("FAIL stall_stb: got %0d expected 2", stb_count); end
        if (s_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", s_valid); end
        if (s_data !== blk[0][31:0]) begin errors++; $display("FAIL stall_head: got %h expected %h", s_data, blk[0][31:0]); end
        if (stall_breaks !== 0) begin errors++; $display("FAIL stall_stable: got %0d breaks expected 0", stall_breaks); end
        finish_block(8, 0, -1);
        vectors += 2;
        if (got_data.size() !== 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", got_data.size()); end
        if (stb_count !== 8) begin errors++; $display("FAIL stall_stb_total: got %0d expected 8", stb_count); end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            vectors++;
            if (got_data[i] !== blk[i][31:0]) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", i, got_data[i], blk[i][31:0]); end
        end
    endtask

    task automatic test_zero_size();
        begin_block(0);
        finish_block(0, 0, -1);
        vectors += 3;
        if (act_ticks !== 1) begin errors++; $display("FAIL zero_act: got %0d clocks expected 1", act_ticks); end
        if (stb_count !== 0) begin errors++; $display("FAIL zero_stb: got %0d expected 0", stb_count); end
        if (got_data.size() !== 0) begin errors++; $display("FAIL zero_beats: got %0d expected 0", got_data.size()); end
    endtask

    task automatic test_last_select();
        fill_block(3, 2);
        begin_block(3);
        finish_block(3, 0, -1);
        vectors++;
        if (got_data.size() !== 3) begin errors++; $display("FAIL lsel_count: got %0d expected 3", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 3; i++) begin
            vectors += 2;
            if (got_last_nl[i] !== (i == 2)) begin errors++; $display("FAIL lsel_index_last[%0d]: got %b expected %b", i, got_last_nl[i], i == 2); end
            if (got_last[i] !== 1'b0) begin errors++; $display("FAIL lsel_bit_last[%0d]: got %b expected 0", i, got_last[i]); end
        end
    endtask

    task automatic test_reset_mid();
        fill_block(6, 1);
        begin_block(6);
        finish_block(6, 0, 2);
        rst_n = 1'b0;
        #1;
        vectors += 4;
        if (o_ppfifo_act !== 1'b0) begin errors++; $display("FAIL mid_act: got %b expected 0", o_ppfifo_act); end
        if (o_ppfifo_stb !== 1'b0) begin errors++; $display("FAIL mid_stb: got %b expected 0", o_ppfifo_stb); end
        if (o_axi_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", o_axi_valid); end
        if ({o_axi_data, o_axi_last} !== 33'h0) begin errors++; $display("FAIL mid_data: got %h expected 0", {o_axi_last, o_axi_data}); end
        i_ppfifo_rdy = 1'b0;
        i_ppfifo_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_block(6, 1);
        begin_block(6);
        finish_block(6, 0, -1);
        vectors += 2;
        if (got_data.size() !== 6) begin errors++; $display("FAIL mid_count: got %0d expected 6", got_data.size()); end
        if (first_valid !== 3) begin errors++; $display("FAIL mid_latency: got %0d expected 3", first_valid); end
        for (int i = 0; i < got_data.size() && i < 6; i++) begin
            vectors++;
            if (got_data[i] !== blk[i][31:0]) begin errors++; $display("FAIL mid_data[%0d]: got %h expected %h", i, got_data[i], blk[i][31:0]); end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 4; b++) begin
            int n;
            n = $urandom_range(1, 12);
            fill_block(n, 1);
            begin_block(n);
            finish_block(n, 2, -1);
            vectors += 4;
            if (got_data.size() !== n) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", got_data.size(), n); end
            if (stb_count !== n) begin errors++; $display("FAIL rnd_stb: got %0d expected %0d", stb_count, n); end
            if (stall_breaks !== 0) begin errors++; $display("FAIL rnd_stable: got %0d breaks expected 0", stall_breaks); end
            if (diverge !== 0) begin errors++; $display("FAIL rnd_variants: got %0d differing clocks expected 0", diverge); end
            for (int i = 0; i < got_data.size() && i < n; i++) begin
                vectors += 3;
                if (got_data[i] !== blk[i][31:0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, got_data[i], blk[i][31:0]); end
                if (got_last[i] !== blk[i][32]) begin errors++; $display("FAIL rnd_last[%0d]: got %b expected %b", i, got_last[i], blk[i][32]); end
                if (got_last_nl[i] !== (i == n - 1)) begin errors++; $display("FAIL rnd_index_last[%0d]: got %b expected %b", i, got_last_nl[i], i == n - 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle_ready();
        test_stall();
        test_zero_size();
        test_last_select();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
